// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues single-cycle memory reads and
// buffers returned words with their PCs in a prefetch FIFO drained by valid/ready.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_data,
    output logic [31:0]              instr_pc,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic          r_inflight;
    logic          r_kill;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];

    logic [CW:0]   w_occupancy;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    // An outstanding read already owns a slot, so a push can never find the FIFO full.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue     = rst & ~redirect_valid & (w_occupancy < (CW+1)'(DEPTH));
    assign w_push      = rst & r_inflight & ~r_kill & ~redirect_valid;
    assign w_pop       = instr_valid & instr_ready;

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr_data  = instr_valid ? r_fifo_data[r_rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
    assign q_count     = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= 32'h0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= redirect_valid & w_issue;
            if (w_issue) begin
                r_pc      <= r_pc + 32'd4;
                r_resp_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc     <= redirect_pc & 32'hFFFF_FFFC;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage is left unreset; the count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a 1-cycle memory returning 0x1000_0000 + word index.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [2:0]  q_count;

    int checks = 0;
    int failures = 0;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .q_count        (q_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_req)
            imem_rdata <= 32'h1000_0000 + (imem_addr >> 2);

    // Leaves the bench in cycle 0, just after reset release, away from the clock edge.
    task automatic start(input logic rdy);
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = rdy;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", q_count); end
        checks++; if (instr_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp 0", instr_data); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
        $display("reset: req=%b valid=%b count=%0d", imem_req, instr_valid, q_count);
    endtask

    task automatic test_fill();
        int reqs = 0;
        start(1'b0);
        for (int n = 0; n < 8; n++) begin
            if (imem_req) begin
                checks++;
                if (imem_addr !== 32'(reqs * 4)) begin failures++; $display("FAIL fill_addr got %h exp %h", imem_addr, 32'(reqs * 4)); end
                reqs++;
            end
            @(negedge clk);
        end
        checks++; if (reqs != 4) begin failures++; $display("FAIL fill_reqs got %0d exp 4", reqs); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fill_req got %b exp 0", imem_req); end
        checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL fill_count got %0d exp 4", q_count); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL fill_pc got %h exp 0", instr_pc); end
        checks++; if (instr_data !== 32'h1000_0000) begin failures++; $display("FAIL fill_data got %h exp 10000000", instr_data); end
        $display("fill: reqs=%0d count=%0d head pc=%h data=%h", reqs, q_count, instr_pc, instr_data);
    endtask

    task automatic test_stream();
        start(1'b1);
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_early got %b exp 0", instr_valid); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got %b exp 1", k, instr_valid); end
            checks++; if (instr_pc !== 32'(4 * k)) begin failures++; $display("FAIL stream_pc[%0d] got %h exp %h", k, instr_pc, 32'(4 * k)); end
            checks++; if (instr_data !== 32'h1000_0000 + 32'(k)) begin failures++; $display("FAIL stream_data[%0d] got %h exp %h", k, instr_data, 32'h1000_0000 + 32'(k)); end
            checks++; if (q_count > 3'd2) begin failures++; $display("FAIL stream_count[%0d] got %0d exp <=2", k, q_count); end
            $display("stream: pc=%h data=%h count=%0d", instr_pc, instr_data, q_count);
        end
    endtask

    task automatic test_redirect();
        start(1'b1);
        repeat (2) @(negedge clk);
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL redir_pc0 got %h exp 0", instr_pc); end
        @(negedge clk);
        checks++; if (instr_pc !== 32'h4) begin failures++; $display("FAIL redir_pc4 got %h exp 4", instr_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h23;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_block got %b exp 0", imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got %b exp 0", instr_valid); end
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL redir_count got %0d exp 0", q_count); end
        checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin failures++; $display("FAIL redir_addr got %h/%b exp 20/1", imem_addr, imem_req); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_gap got %b exp 0", instr_valid); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20) begin failures++; $display("FAIL redir_first got %b/%h exp 1/20", instr_valid, instr_pc); end
        checks++; if (instr_data !== 32'h1000_0008) begin failures++; $display("FAIL redir_data got %h exp 10000008", instr_data); end
        @(negedge clk);
        checks++; if (instr_pc !== 32'h24) begin failures++; $display("FAIL redir_next got %h exp 24", instr_pc); end
        $display("redirect: resumed at pc=%h", instr_pc);
    endtask

    task automatic test_full_push_pop();
        start(1'b0);
        repeat (4) @(negedge clk);
        checks++; if (q_count !== 3'd3) begin failures++; $display("FAIL pp_count3 got %0d exp 3", q_count); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL pp_req got %b exp 0", imem_req); end
        instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (q_count !== 3'd3) begin failures++; $display("FAIL pp_count_same got %0d exp 3", q_count); end
        checks++; if (instr_pc !== 32'h4 || instr_data !== 32'h1000_0001) begin failures++; $display("FAIL pp_head got %h/%h exp 4/10000001", instr_pc, instr_data); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (instr_pc !== 32'(8 + 4 * k)) begin failures++; $display("FAIL pp_order[%0d] got %h exp %h", k, instr_pc, 32'(8 + 4 * k)); end
        end
        checks++; if (instr_data !== 32'h1000_0004) begin failures++; $display("FAIL pp_data got %h exp 10000004", instr_data); end
        $display("push_pop: head pc=%h count=%0d", instr_pc, q_count);
    endtask

    task automatic test_wrap();
        start(1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_block got %b exp 0", imem_req); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_a0 got %b/%h exp 1/fffffff8", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_a1 got %h exp fffffffc", imem_addr); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_a2 got %h exp 0", imem_addr); end
        checks++; if (instr_pc !== 32'hFFFF_FFF8 || instr_data !== 32'h4FFF_FFFE) begin failures++; $display("FAIL wrap_d0 got %h/%h exp fffffff8/4ffffffe", instr_pc, instr_data); end
        @(negedge clk);
        checks++; if (instr_pc !== 32'hFFFF_FFFC || instr_data !== 32'h4FFF_FFFF) begin failures++; $display("FAIL wrap_d1 got %h/%h exp fffffffc/4fffffff", instr_pc, instr_data); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'h1000_0000) begin failures++; $display("FAIL wrap_d2 got %b/%h/%h exp 1/0/10000000", instr_valid, instr_pc, instr_data); end
        $display("wrap: pc=%h data=%h", instr_pc, instr_data);
    endtask

    task automatic test_async_reset();
        start(1'b0);
        repeat (3) @(negedge clk);
        checks++; if (q_count !== 3'd2) begin failures++; $display("FAIL ar_pre got %0d exp 2", q_count); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || q_count !== 3'd0) begin failures++; $display("FAIL ar_clear got %b/%0d exp 0/0", instr_valid, q_count); end
        checks++; if (imem_req !== 1'b0 || instr_pc !== 32'h0 || instr_data !== 32'h0) begin failures++; $display("FAIL ar_outs got %b/%h/%h exp 0/0/0", imem_req, instr_pc, instr_data); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL ar_restart got %b/%h exp 1/0", imem_req, imem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'h1000_0000) begin failures++; $display("FAIL ar_first got %b/%h/%h exp 1/0/10000000", instr_valid, instr_pc, instr_data); end
        checks++; if (q_count !== 3'd1) begin failures++; $display("FAIL ar_count got %0d exp 1", q_count); end
        $display("async_reset: restart pc=%h count=%0d", instr_pc, q_count);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_full_push_pop();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
